// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction memory between IF fetch (A) and the loader/debug port (B),
// and holds the pipeline in BOOT until the loader finishes.
module imem_port_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic [31:0]       a_addr,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic              hold,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [31:0]       b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    input  logic              boot_done,
    input  logic              soft_boot,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              dbg_state,
    output logic [3:0]        dbg_wait_cnt
);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] wait_cnt;
    logic       starved;
    logic       unused_addr_bits;

    assign starved = (wait_cnt == 4'(MAX_WAIT));

    // Handshake: a request is accepted in the same cycle its gnt is high; read data
    // follows exactly one cycle later with rvalid. Nothing is granted while rst is high.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        hold  = 1'b1;
        if (!rst) begin
            if (state == ST_BOOT) begin
                b_gnt = b_req;
            end else begin
                b_gnt = b_req & (~a_req | starved);
                a_gnt = a_req & ~b_gnt;
                hold  = a_req & ~a_gnt;
            end
        end
    end

    assign mem_en    = a_gnt | b_gnt;
    assign mem_we    = b_gnt & b_we;
    assign mem_addr  = b_gnt ? b_addr[ADDR_W+1:2] : a_addr[ADDR_W+1:2];
    assign mem_wdata = b_wdata;
    assign a_rdata   = mem_rdata;
    assign b_rdata   = mem_rdata;

    assign dbg_state    = state;
    assign dbg_wait_cnt = wait_cnt;

    // Byte-lane and out-of-range address bits have no meaning for a word-wide memory.
    assign unused_addr_bits = ^{a_addr[31:ADDR_W+2], a_addr[1:0],
                                b_addr[31:ADDR_W+2], b_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_BOOT;
            wait_cnt <= 4'd0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
        end else begin
            a_rvalid <= a_gnt;
            b_rvalid <= b_gnt & ~b_we;

            case (state)
                ST_BOOT: if (boot_done) state <= ST_RUN;
                ST_RUN:  if (soft_boot) state <= ST_BOOT;
                default: state <= ST_BOOT;
            endcase

            if (state == ST_BOOT || b_gnt || !b_req) begin
                wait_cnt <= 4'd0;
            end else if (!starved) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Arbiter and boot sequencer for the single-port instruction memory of the pipelined MIPS core. It shares the memory between two requesters: the IF-stage fetch (port A, read-only) and the program loader/debug port (port B, read/write). After reset, it holds the pipeline in a BOOT state until the loader signals completion. It drives the memory command (enable, write, word address, data) and routes the one-cycle-latency read data back to the requester that issued the read.

## Interface
Parameters:
- ADDR_W, 12, word-address width; memory index is byte address bits [ADDR_W+1:2].
- DATA_W, 32, data width.
- MAX_WAIT, 4, maximum consecutive cycles port B may be refused while requesting; range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- a_req  in  1  fetch read request.
- a_addr  in  32  fetch byte address.
- a_gnt  out  1  fetch request accepted this cycle (combinational).
- a_rvalid  out  1  a_rdata valid (registered).
- a_rdata  out  DATA_W  fetch read data.
- hold  out  1  stall to the PC/IF stage.
- b_req  in  1  loader request.
- b_we  in  1  1 = write, 0 = read.
- b_addr  in  32  loader byte address.
- b_wdata  in  DATA_W  loader write data.
- b_gnt  out  1  loader request accepted this cycle (combinational).
- b_rvalid  out  1  b_rdata valid; reads only.
- b_rdata  out  DATA_W  loader read data.
- boot_done  in  1  loader finished; leave BOOT.
- soft_boot  in  1  re-enter BOOT from RUN.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  word index.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read command.

## Operation
- States: BOOT and RUN. Reset enters BOOT.
- BOOT → RUN when boot_done=1 is sampled. RUN → BOOT when soft_boot=1 is sampled. If both are high, soft_boot wins in RUN; in BOOT, boot_done wins.
- In BOOT:
  - a_gnt=0 and hold=1.
  - b_gnt=b_req.
- In RUN, port A has priority, except for starvation:
  - b_win = b_req & (~a_req | wait_cnt==MAX_WAIT).
  - b_gnt = b_win.
  - a_gnt = a_req & ~b_win.
  - hold = a_req & ~a_gnt.
- wait_cnt (4-bit):
  - Cleared on reset, in BOOT, when b_gnt=1, or when b_req=0.
  - Otherwise it increments, saturating at MAX_WAIT.
- Memory command is combinational from the grant:
  - mem_en = a_gnt | b_gnt.
  - mem_we = b_gnt & b_we.
  - mem_addr = granted port's address bits [ADDR_W+1:2]; bits [1:0] are ignored.
  - mem_wdata = b_wdata.
- Response:
  - a_rvalid is registered from a_gnt.
  - b_rvalid is registered from b_gnt & ~b_we.
  - a_rdata and b_rdata carry mem_rdata.
  - A rvalid is never lost: a response is issued for every read accepted in the previous cycle, even across a state change.
- Writes complete at grant and produce no response.
- When no grant is issued, mem_en=0, mem_we=0, and mem_addr/mem_wdata are don't-care.

## Timing
- Reset values:
  - State = BOOT, wait_cnt = 0.
  - a_rvalid = 0, b_rvalid = 0.
  - a_gnt = 0, b_gnt = 0, mem_en = 0, mem_we = 0.
  - hold = 1.
- Grant latency: 0 cycles, same cycle as the request.
- Read data latency: 1 cycle after grant.
- Throughput: one access per cycle total.
- The rst-cycle grant is 0. rvalid in the cycle after rst is 0, even if a read was granted in the cycle rst was asserted.
- boot_done sampled at edge N: RUN from cycle N+1, so a_gnt is possible in cycle N+1.
- Starvation bound: with a_req and b_req held high in RUN, B is granted on the (MAX_WAIT+1)th cycle. The pattern then repeats: A is granted MAX_WAIT cycles, then B once.

## Test plan
- **Reset:** hold rst for 2 cycles → hold=1, all grants/rvalid=0, mem_en=0. Then a_req=1 with no boot_done → a_gnt stays 0, hold=1.
- **Boot load:** write 0x20080005, 0x20090003, 0x01095020 to byte addresses 0x0, 0x4, 0x8 → mem_we=1 with mem_addr 0, 1, 2. Read back addr 0x4 → b_rvalid one cycle later with 0x20090003. Then pulse boot_done → hold falls in the next cycle.
- **Fetch read:** RUN, a_req at 0x8 → a_gnt same cycle; a_rvalid=1 with a_rdata=0x01095020 one cycle later; hold=0 throughout.
- **Priority and starvation:** MAX_WAIT=4, a_req and b_req (read 0x0) held high → a_gnt for 4 cycles, then b_gnt with hold=1 that cycle, b_rvalid=1 one cycle later; the pattern repeats.
- **soft_boot mid-run:** soft_boot asserted with a_req held → the fetch granted in that cycle still gets its a_rvalid; hold=1 from the next cycle; loader accesses are served until boot_done.
- **Reset mid-read:** rst asserted in the cycle a read is granted → no rvalid in the following cycle; state BOOT; wait_cnt=0.
